// File: rtl/legv8_pkg.sv
// ============================================================================
// Module   : legv8_pkg
// Brief    : Shared LEGv8 decode constants, control bundle and opcode classifier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package legv8_pkg;

   localparam logic [4:0]  c_xzr          = 5'd31;

   // Opcodes on Instruction[31:21]; '?' marks don't-care bits for casez.
   localparam logic [10:0] c_op_add       = 11'b10001011000;
   localparam logic [10:0] c_op_sub       = 11'b11001011000;
   localparam logic [10:0] c_op_and       = 11'b10001010000;
   localparam logic [10:0] c_op_orr       = 11'b10101010000;
   localparam logic [10:0] c_op_addi      = 11'b1001000100?;
   localparam logic [10:0] c_op_subi      = 11'b1101000100?;
   localparam logic [10:0] c_op_ldur      = 11'b11111000010;
   localparam logic [10:0] c_op_stur      = 11'b11111000000;
   localparam logic [10:0] c_op_cbz       = 11'b10110100???;
   localparam logic [10:0] c_op_cbnz      = 11'b10110101???;
   localparam logic [10:0] c_op_b         = 11'b000101?????;

   localparam logic [1:0]  c_alusrc_reg   = 2'b00;
   localparam logic [1:0]  c_alusrc_sext  = 2'b01;
   localparam logic [1:0]  c_alusrc_imm12 = 2'b10;

   localparam logic [1:0]  c_aluop_add    = 2'b00;
   localparam logic [1:0]  c_aluop_pass   = 2'b01;
   localparam logic [1:0]  c_aluop_funct  = 2'b10;

   typedef enum logic [2:0] {
      cls_r   = 3'd0,
      cls_i   = 3'd1,
      cls_ld  = 3'd2,
      cls_st  = 3'd3,
      cls_cb  = 3'd4,
      cls_b   = 3'd5,
      cls_ill = 3'd6
   } iclass_t;

   typedef struct packed {
      logic [1:0] alusrc;
      logic [1:0] aluop;
      logic       b;
      logic       bz;
      logic       bnz;
      logic       mem_write;
      logic       mem_read;
      logic       memto_reg;
      logic       reg_write;
   } ctrl_t;

   function automatic iclass_t classify(input logic [10:0] op);
      casez (op)
         c_op_add, c_op_sub, c_op_and, c_op_orr: return cls_r;
         c_op_addi, c_op_subi:                   return cls_i;
         c_op_ldur:                              return cls_ld;
         c_op_stur:                              return cls_st;
         c_op_cbz, c_op_cbnz:                    return cls_cb;
         c_op_b:                                 return cls_b;
         default:                                return cls_ill;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// Module   : register_file
// Brief    : 2R/1W register file with hard-wired zero register and write-through.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file
#(
   parameter int NUM_REGS = 32,
   parameter int DATA_W   = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [$clog2(NUM_REGS)-1:0] i_raddr1,
   input  logic [$clog2(NUM_REGS)-1:0] i_raddr2,
   input  logic                        i_we,
   input  logic [$clog2(NUM_REGS)-1:0] i_waddr,
   input  logic [DATA_W-1:0]           i_wdata,
   output logic [DATA_W-1:0]           o_rdata1,
   output logic [DATA_W-1:0]           o_rdata2
);

   localparam int            AW        = $clog2(NUM_REGS);
   localparam logic [AW-1:0] c_xzr_idx = AW'(NUM_REGS - 1);

   logic [DATA_W-1:0] r_regs [NUM_REGS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_waddr != c_xzr_idx)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   // Write-through lets decode see write-back data in the same cycle.
   assign o_rdata1 = (i_raddr1 == c_xzr_idx)               ? '0      :
                     (i_we && (i_waddr == i_raddr1))       ? i_wdata :
                                                             r_regs[i_raddr1];
   assign o_rdata2 = (i_raddr2 == c_xzr_idx)               ? '0      :
                     (i_we && (i_waddr == i_raddr2))       ? i_wdata :
                                                             r_regs[i_raddr2];

endmodule

`default_nettype wire

// File: rtl/instruction_decode.sv
// ============================================================================
// Module   : instruction_decode
// Brief    : LEGv8 decode stage with register file, immediate gen and load-use stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_decode
   import legv8_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int DATA_W   = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [63:0]       IFIDAddress,
   input  logic [31:0]       IFIDInstruction,
   input  logic              IFIDValid,
   input  logic              PCSrc,
   input  logic              WBRegWrite,
   input  logic [4:0]        WBReg,
   input  logic [DATA_W-1:0] WBData,
   output logic              Stall,
   output logic [63:0]       Address,
   output logic [31:0]       Instruction,
   output logic [DATA_W-1:0] signExtInstr,
   output logic [DATA_W-1:0] Data1,
   output logic [DATA_W-1:0] Data2,
   output logic [1:0]        ALUSrc,
   output logic [1:0]        ALUOp,
   output logic              B,
   output logic              BZ,
   output logic              BNZ,
   output logic              MemWrite,
   output logic              MemRead,
   output logic              MemtoReg,
   output logic              RegWrite,
   output logic              IllegalInstr
);

   logic [31:0]       w_ins;
   iclass_t           w_cls;
   ctrl_t             w_ctrl;
   logic [DATA_W-1:0] w_imm;
   logic              w_uses2;
   logic              w_use_rt;
   logic [4:0]        w_rn;
   logic [4:0]        w_rm;
   logic [DATA_W-1:0] w_rdata1;
   logic [DATA_W-1:0] w_rdata2;
   logic              w_stall;
   logic              w_legal;
   logic              w_accept;

   ctrl_t             r_ctrl;
   logic [63:0]       r_addr;
   logic [31:0]       r_instr;
   logic [DATA_W-1:0] r_imm;
   logic [DATA_W-1:0] r_data1;
   logic [DATA_W-1:0] r_data2;
   logic              r_illegal;

   assign w_ins = IFIDInstruction;
   assign w_cls = classify(w_ins[31:21]);

   always_comb begin
      w_ctrl   = '0;
      w_imm    = '0;
      w_uses2  = 1'b0;
      w_use_rt = 1'b0;
      case (w_cls)
         cls_r: begin
            w_ctrl.alusrc    = c_alusrc_reg;
            w_ctrl.aluop     = c_aluop_funct;
            w_ctrl.reg_write = 1'b1;
            w_uses2          = 1'b1;
         end
         cls_i: begin
            w_ctrl.alusrc    = c_alusrc_imm12;
            w_ctrl.aluop     = c_aluop_funct;
            w_ctrl.reg_write = 1'b1;
            w_imm            = {{(DATA_W-12){1'b0}}, w_ins[21:10]};
         end
         cls_ld: begin
            w_ctrl.alusrc    = c_alusrc_sext;
            w_ctrl.aluop     = c_aluop_add;
            w_ctrl.mem_read  = 1'b1;
            w_ctrl.memto_reg = 1'b1;
            w_ctrl.reg_write = 1'b1;
            w_imm            = {{(DATA_W-9){w_ins[20]}}, w_ins[20:12]};
         end
         cls_st: begin
            w_ctrl.alusrc    = c_alusrc_sext;
            w_ctrl.aluop     = c_aluop_add;
            w_ctrl.mem_write = 1'b1;
            w_imm            = {{(DATA_W-9){w_ins[20]}}, w_ins[20:12]};
            w_uses2          = 1'b1;
            w_use_rt         = 1'b1;
         end
         cls_cb: begin
            // Instruction[24] separates CBNZ from CBZ.
            w_ctrl.aluop     = c_aluop_pass;
            w_ctrl.bz        = ~w_ins[24];
            w_ctrl.bnz       = w_ins[24];
            w_imm            = {{(DATA_W-19){w_ins[23]}}, w_ins[23:5]};
            w_uses2          = 1'b1;
            w_use_rt         = 1'b1;
         end
         cls_b: begin
            w_ctrl.b         = 1'b1;
            w_imm            = {{(DATA_W-26){w_ins[25]}}, w_ins[25:0]};
         end
         default: begin
            w_ctrl           = '0;
         end
      endcase
   end

   assign w_rn = w_ins[9:5];
   assign w_rm = w_use_rt ? w_ins[4:0] : w_ins[20:16];

   register_file #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_raddr1 (w_rn),
      .i_raddr2 (w_rm),
      .i_we     (WBRegWrite),
      .i_waddr  (WBReg),
      .i_wdata  (WBData),
      .o_rdata1 (w_rdata1),
      .o_rdata2 (w_rdata2)
   );

   // Load in ID/EX whose destination feeds this instruction; a flush overrides.
   assign w_stall = rst_n && IFIDValid && !PCSrc && r_ctrl.mem_read
                 && (r_instr[4:0] != c_xzr)
                 && ((r_instr[4:0] == w_rn) || (w_uses2 && (r_instr[4:0] == w_rm)));

   assign w_legal  = (w_cls != cls_ill);
   assign w_accept = IFIDValid && !PCSrc && !w_stall;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ctrl    <= '0;
         r_addr    <= '0;
         r_instr   <= '0;
         r_imm     <= '0;
         r_data1   <= '0;
         r_data2   <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_ctrl    <= (w_accept && w_legal) ? w_ctrl : '0;
         r_addr    <= IFIDAddress;
         r_instr   <= w_ins;
         r_imm     <= w_imm;
         r_data1   <= w_rdata1;
         r_data2   <= w_rdata2;
         r_illegal <= w_accept && !w_legal;
      end
   end

   assign Stall        = w_stall;
   assign Address      = r_addr;
   assign Instruction  = r_instr;
   assign signExtInstr = r_imm;
   assign Data1        = r_data1;
   assign Data2        = r_data2;
   assign ALUSrc       = r_ctrl.alusrc;
   assign ALUOp        = r_ctrl.aluop;
   assign B            = r_ctrl.b;
   assign BZ           = r_ctrl.bz;
   assign BNZ          = r_ctrl.bnz;
   assign MemWrite     = r_ctrl.mem_write;
   assign MemRead      = r_ctrl.mem_read;
   assign MemtoReg     = r_ctrl.memto_reg;
   assign RegWrite     = r_ctrl.reg_write;
   assign IllegalInstr = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_instruction_decode.sv
// ============================================================================
// Module   : tb_instruction_decode
// Brief    : Directed and randomized checks of instruction_decode against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_decode;

   logic        clk;
   logic        rst_n;
   logic [63:0] IFIDAddress;
   logic [31:0] IFIDInstruction;
   logic        IFIDValid;
   logic        PCSrc;
   logic        WBRegWrite;
   logic [4:0]  WBReg;
   logic [63:0] WBData;
   logic        Stall;
   logic [63:0] Address;
   logic [31:0] Instruction;
   logic [63:0] signExtInstr;
   logic [63:0] Data1;
   logic [63:0] Data2;
   logic [1:0]  ALUSrc;
   logic [1:0]  ALUOp;
   logic        B, BZ, BNZ, MemWrite, MemRead, MemtoReg, RegWrite, IllegalInstr;

   instruction_decode #(.NUM_REGS(32), .DATA_W(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .IFIDAddress(IFIDAddress), .IFIDInstruction(IFIDInstruction), .IFIDValid(IFIDValid),
      .PCSrc(PCSrc), .WBRegWrite(WBRegWrite), .WBReg(WBReg), .WBData(WBData),
      .Stall(Stall), .Address(Address), .Instruction(Instruction), .signExtInstr(signExtInstr),
      .Data1(Data1), .Data2(Data2), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
      .B(B), .BZ(BZ), .BNZ(BNZ), .MemWrite(MemWrite), .MemRead(MemRead),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .IllegalInstr(IllegalInstr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: architectural registers plus the ID/EX facts the hazard rule needs.
   logic [63:0] m_regs [32];
   logic        m_mr;
   logic [4:0]  m_prev_rd;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // 0 R, 1 I, 2 LDUR, 3 STUR, 4 CBZ, 5 CBNZ, 6 B, 7 illegal
   function automatic int kind(input logic [31:0] ins);
      int op;
      op = int'(ins[31:21]);
      if (op == 'h458 || op == 'h658 || op == 'h450 || op == 'h550) return 0;
      if ((op >> 1) == 'h244 || (op >> 1) == 'h344) return 1;
      if (op == 'h7C2) return 2;
      if (op == 'h7C0) return 3;
      if ((op >> 3) == 'hB4) return 4;
      if ((op >> 3) == 'hB5) return 5;
      if ((op >> 5) == 'h05) return 6;
      return 7;
   endfunction

   // {ALUSrc, ALUOp, B, BZ, BNZ, MemWrite, MemRead, MemtoReg, RegWrite}
   function automatic logic [10:0] ctrl_of(input int k);
      case (k)
         0:       return {2'b00, 2'b10, 7'b0000001};
         1:       return {2'b10, 2'b10, 7'b0000001};
         2:       return {2'b01, 2'b00, 7'b0000111};
         3:       return {2'b01, 2'b00, 7'b0001000};
         4:       return {2'b00, 2'b01, 7'b0100000};
         5:       return {2'b00, 2'b01, 7'b0010000};
         6:       return {2'b00, 2'b00, 7'b1000000};
         default: return 11'd0;
      endcase
   endfunction

   function automatic longint sx(input longint v, input int n);
      return (v >= (64'sd1 <<< (n - 1))) ? v - (64'sd1 <<< n) : v;
   endfunction

   function automatic logic [63:0] rd(input logic [4:0] idx, input logic we,
                                      input logic [4:0] wr, input logic [63:0] wd);
      if (idx == 5'd31) return 64'd0;
      if (we && wr == idx) return wd;
      return m_regs[idx];
   endfunction

   task automatic step(input logic rn, input logic [63:0] a, input logic [31:0] ins,
                       input logic v, input logic pc, input logic we,
                       input logic [4:0] wr, input logic [63:0] wd);
      int          k;
      logic [4:0]  rn_i, rm_i;
      bit          uses2, exp_stall, bubble, ill;
      longint      imm;
      logic [63:0] d1, d2;
      logic [10:0] ec;
      rst_n = rn; IFIDAddress = a; IFIDInstruction = ins; IFIDValid = v;
      PCSrc = pc; WBRegWrite = we; WBReg = wr; WBData = wd;
      #1;
      k     = kind(ins);
      rn_i  = ins[9:5];
      rm_i  = (k == 3 || k == 4 || k == 5) ? ins[4:0] : ins[20:16];
      uses2 = (k == 0 || k == 3 || k == 4 || k == 5);
      exp_stall = rn && v && !pc && m_mr && (m_prev_rd != 5'd31)
               && (m_prev_rd == rn_i || (uses2 && m_prev_rd == rm_i));
      chk("stall", {63'd0, Stall}, {63'd0, exp_stall});
      d1 = rd(rn_i, we, wr, wd);
      d2 = rd(rm_i, we, wr, wd);
      case (k)
         1:       imm = longint'(ins[21:10]);
         2, 3:    imm = sx(longint'(ins[20:12]), 9);
         4, 5:    imm = sx(longint'(ins[23:5]), 19);
         6:       imm = sx(longint'(ins[25:0]), 26);
         default: imm = 0;
      endcase
      @(posedge clk);
      #1;
      if (!rn) begin
         chk("rst_ctrl", {53'd0, ALUSrc, ALUOp, B, BZ, BNZ, MemWrite, MemRead, MemtoReg, RegWrite}, 64'd0);
         chk("rst_ill", {63'd0, IllegalInstr}, 64'd0);
         chk("rst_addr", Address, 64'd0);
         chk("rst_instr", {32'd0, Instruction}, 64'd0);
         chk("rst_imm", signExtInstr, 64'd0);
         chk("rst_data", Data1 | Data2, 64'd0);
         for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
         m_mr = 1'b0;
         m_prev_rd = 5'd0;
      end else begin
         bubble = pc || !v || exp_stall || (k == 7);
         ill    = v && !pc && !exp_stall && (k == 7);
         ec     = bubble ? 11'd0 : ctrl_of(k);
         chk("ctrl", {53'd0, ALUSrc, ALUOp, B, BZ, BNZ, MemWrite, MemRead, MemtoReg, RegWrite},
             {53'd0, ec});
         chk("illegal", {63'd0, IllegalInstr}, {63'd0, ill});
         if (!bubble) begin
            chk("addr", Address, a);
            chk("instr", {32'd0, Instruction}, {32'd0, ins});
            chk("imm", signExtInstr, 64'(imm));
            chk("data1", Data1, d1);
            chk("data2", Data2, d2);
         end
         m_mr      = ec[2];
         m_prev_rd = ins[4:0];
         if (we && wr != 5'd31) m_regs[wr] = wd;
      end
      @(negedge clk);
   endtask

   function automatic logic [31:0] rtype(input logic [10:0] op, input logic [4:0] rm,
                                         input logic [4:0] rn, input logic [4:0] rdst);
      return {op, rm, 6'd0, rn, rdst};
   endfunction

   function automatic logic [4:0] pick();
      int r;
      r = $urandom_range(0, 8);
      return (r == 8) ? 5'd31 : 5'(r);
   endfunction

   function automatic logic [31:0] rand_ins();
      logic [10:0] rops [4];
      rops = '{11'h458, 11'h658, 11'h450, 11'h550};
      case ($urandom_range(0, 7))
         0: return {rops[$urandom_range(0, 3)], pick(), 6'($urandom), pick(), pick()};
         1: return {($urandom_range(0, 1) != 0) ? 10'h244 : 10'h344, 12'($urandom), pick(), pick()};
         2: return {11'h7C2, 9'($urandom), 2'b00, pick(), pick()};
         3: return {11'h7C0, 9'($urandom), 2'b00, pick(), pick()};
         4: return {8'hB4, 19'($urandom), pick()};
         5: return {8'hB5, 19'($urandom), pick()};
         6: return {6'h05, 26'($urandom)};
         default: return $urandom;
      endcase
   endfunction

   localparam logic [31:0] ADD_3_1_2 = 32'h8B02_0023;   // ADD X3,X1,X2
   localparam logic [31:0] LDUR_4_1  = 32'hF85F_8024;   // LDUR X4,[X1,#-8]
   localparam logic [31:0] ADD_5_4_2 = 32'h8B02_0085;   // ADD X5,X4,X2

   initial begin
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      m_mr = 1'b0;
      m_prev_rd = 5'd0;
      @(negedge clk);

      step(0, 64'h40, ADD_3_1_2, 1, 0, 0, 5'd0, 64'd0);
      step(0, 64'h44, 32'hFFFF_FFFF, 1, 0, 1, 5'd1, 64'd99);
      step(1, 64'h0, 32'd0, 0, 0, 1, 5'd1, 64'd5);
      step(1, 64'h0, 32'd0, 0, 0, 1, 5'd2, 64'd7);

      step(1, 64'h100, rtype(11'h458, 5'd2, 5'd1, 5'd3), 1, 0, 0, 5'd0, 64'd0);
      chk("add_data1", Data1, 64'd5);
      chk("add_data2", Data2, 64'd7);

      step(1, 64'h104, LDUR_4_1, 1, 0, 0, 5'd0, 64'd0);
      chk("ldur_imm", signExtInstr, 64'hFFFF_FFFF_FFFF_FFF8);
      step(1, 64'h108, ADD_5_4_2, 1, 0, 0, 5'd0, 64'd0);
      chk("hazard_bubble", {63'd0, RegWrite}, 64'd0);
      step(1, 64'h108, ADD_5_4_2, 1, 0, 0, 5'd0, 64'd0);
      chk("hazard_issue", {63'd0, RegWrite}, 64'd1);

      step(1, 64'h0, 32'd0, 0, 0, 1, 5'd31, 64'hDEAD);
      step(1, 64'h10C, rtype(11'h458, 5'd31, 5'd31, 5'd3), 1, 0, 0, 5'd0, 64'd0);
      chk("xzr_read", Data1, 64'd0);
      step(1, 64'h110, rtype(11'h458, 5'd6, 5'd6, 5'd7), 1, 0, 1, 5'd6, 64'd9);
      chk("bypass", Data1 ^ Data2 ^ 64'd9, 64'd9);

      step(1, 64'h114, {8'hB4, 19'h7FFFF, 5'd2}, 1, 0, 0, 5'd0, 64'd0);
      chk("cbz_imm", signExtInstr, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("cbz_rt", Data2, 64'd7);
      step(1, 64'h118, {6'h05, 26'h10}, 1, 0, 0, 5'd0, 64'd0);
      chk("b_imm", signExtInstr, 64'd16);

      step(1, 64'h11C, ADD_3_1_2, 1, 1, 0, 5'd0, 64'd0);
      step(1, 64'h120, LDUR_4_1, 1, 0, 0, 5'd0, 64'd0);
      step(1, 64'h124, ADD_5_4_2, 1, 1, 0, 5'd0, 64'd0);

      step(1, 64'h128, {11'h7FF, 21'd0}, 1, 0, 0, 5'd0, 64'd0);
      chk("illegal_pulse", {63'd0, IllegalInstr}, 64'd1);
      step(1, 64'h12C, ADD_3_1_2, 1, 0, 0, 5'd0, 64'd0);

      step(1, 64'h130, LDUR_4_1, 1, 0, 0, 5'd0, 64'd0);
      step(0, 64'h134, ADD_5_4_2, 1, 0, 0, 5'd0, 64'd0);
      step(1, 64'h0, 32'd0, 0, 0, 1, 5'd2, 64'd7);

      for (int n = 0; n < 500; n++) begin
         step(($urandom_range(0, 59) != 0),
              {$urandom, $urandom},
              rand_ins(),
              ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 1) != 0),
              pick(),
              {$urandom, $urandom});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- LEGv8 decode stage; sits directly upstream of the execution stage and produces its full input bundle through a registered ID/EX boundary.
- Contains the 32x64 register file (X31 = XZR), the main control decoder, immediate sign/zero extension and load-use hazard detection.
- Consumes the IF/ID bundle and the write-back port; drives the stall signal back to fetch.

Parameters:
- NUM_REGS, 32, architectural register count; index NUM_REGS-1 is XZR.
- DATA_W, 64, register and datapath width.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- IFIDAddress  in  64  PC of the instruction in IF/ID.
- IFIDInstruction  in  32  instruction word in IF/ID.
- IFIDValid  in  1  IF/ID holds a real instruction.
- PCSrc  in  1  branch taken, resolved downstream; flush.
- WBRegWrite  in  1  write-back enable.
- WBReg  in  5  write-back destination.
- WBData  in  64  write-back data.
- Stall  out  1  combinational; holds PC and IF/ID this cycle.
- Address  out  64  registered PC.
- Instruction  out  32  registered instruction.
- signExtInstr  out  64  registered extended immediate.
- Data1  out  64  registered Rn read.
- Data2  out  64  registered Rm/Rt read.
- ALUSrc  out  2  00 reg, 01 signExt, 10 Instruction[21:10].
- ALUOp  out  2  00 add, 01 pass-for-zero-test, 10 funct.
- B, BZ, BNZ, MemWrite, MemRead, MemtoReg, RegWrite  out  1 each  registered controls.
- IllegalInstr  out  1  registered one-cycle pulse.

Behaviour:
- Reset (rst_n=0 at edge): all 32 registers are 0. Every registered output is 0, which forms a bubble. Reset mid-stall drops the stall and the bubble state. Stall is 0 while rst_n=0.
- Latency: exactly 1 cycle from IF/ID to ID/EX outputs.
- Decode, with opcode matched on Instruction[31:21] by prefix:
  - R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: ALUSrc=00, ALUOp=10, RegWrite=1.
  - ADDI 1001000100x, SUBI 1101000100x: ALUSrc=10, ALUOp=10, RegWrite=1.
  - LDUR 11111000010: ALUSrc=01, ALUOp=00, MemRead=1, MemtoReg=1, RegWrite=1.
  - STUR 11111000000: ALUSrc=01, ALUOp=00, MemWrite=1.
  - CBZ 10110100xxx: ALUOp=01, BZ=1. CBNZ 10110101xxx: ALUOp=01, BNZ=1. B 000101xxxxx: B=1.
  - Anything else, with IFIDValid=1: bubble plus IllegalInstr=1 for one cycle.
- Register read indices: Rn = Instr[9:5]. Second index = Instr[4:0] (Rt) for STUR/CBZ/CBNZ, otherwise Instr[20:16].
- Immediate generation:
  - D-format: sign-extend [20:12].
  - CB: sign-extend [23:5].
  - B: sign-extend [25:0].
  - I-type: zero-extend [21:10].
  - R-type: 0.
- Register file:
  - Write occurs at the edge when WBRegWrite=1 and WBReg!=31.
  - Reads of X31 return 0.
  - Same-cycle read of WBReg (WBRegWrite=1, WBReg!=31) returns WBData (write-through bypass).
- Load-use hazard: Stall=1 when all of the following hold:
  - the registered MemRead=1;
  - the registered Instruction[4:0] != 31;
  - it equals Rn, or equals the second index when that operand is used (R-type, STUR, CBZ/CBNZ);
  - IFIDValid=1.
  - While Stall=1: ID/EX loads a bubble and the IF/ID instruction is re-decoded next cycle.
  - One stall cycle suffices; the bubble clears MemRead.
- Flush: PCSrc=1 loads a bubble regardless of decode and suppresses Stall and IllegalInstr. PCSrc has priority over stall.
- IFIDValid=0: bubble, no IllegalInstr.
- Bubble definition: all control outputs 0. Address, Instruction and data may hold any value, except Instruction=0 on reset.

Decomposition:
- Shared package legv8_pkg holds:
  - opcode constants;
  - ALUSrc/ALUOp encodings;
  - a ctrl_t struct (ALUSrc, ALUOp, B, BZ, BNZ, MemWrite, MemRead, MemtoReg, RegWrite);
  - constant XZR=31.
- One natural sub-module: register_file (32x64, 2 read ports, 1 write port, XZR, bypass, synchronous reset).
- Control decode, immediate extension and hazard logic stay in the top level.

Test Plan:
- Reset, then write X1=5 and X2=7 via WB; ADD X3,X1,X2 -> next cycle Data1=5, Data2=7, ALUSrc=00, ALUOp=10, RegWrite=1.
- LDUR X4,[X1,#-8] -> signExtInstr=0xFFFF_FFFF_FFFF_FFF8, MemRead=MemtoReg=RegWrite=1, ALUSrc=01. Following ADD X5,X4,X2 -> Stall=1 for one cycle with a bubble in ID/EX, then ADD issues with Stall=0.
- WBRegWrite=1, WBReg=31, WBData=0xDEAD; then read X31 -> Data1=0. Same-cycle WB to X6=9 while decoding ADD X7,X6,X6 -> Data1=Data2=9.
- CBZ X2 with imm19=-1 -> BZ=1, ALUOp=01, Data2 from Rt=X2, signExtInstr=all ones. B imm26=0x10 -> B=1, signExtInstr=16.
- PCSrc=1 during a valid ADD, and separately during a load-use hazard -> all controls 0 next cycle, Stall=0.
- Opcode 0x7FF with IFIDValid=1 -> IllegalInstr=1 for one cycle, RegWrite=0. rst_n=0 asserted while Stall=1 -> Stall=0 and all outputs 0 after the edge.
